// File: rtl/ha_ripple_pkg.sv
// Shared definitions for the half-adder ripple-carry adder.
// Optional feature macro used by the top: HA_RIPPLE_OVF_EN (signed overflow output).
package ha_ripple_pkg;

    // Widest operand the adder is meant to be built at.
    localparam int MAX_WIDTH = 32;

    // Result bundle for consumers that pass a full-width sum plus carry around.
    typedef struct {
        logic [MAX_WIDTH-1:0] sum;
        logic                 c_out;
    } add_res_t;

endpackage : ha_ripple_pkg

// File: rtl/ha_cell.sv
// Half-adder leaf cell: sum is the XOR of the inputs, carry is their AND.
module ha_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule : ha_cell

// File: rtl/ha_ripple_adder.sv
// Registered WIDTH-bit ripple-carry adder assembled from half-adder cells.
// Each bit is HA / HA / NAND-OR, so the carry path is traceable gate by gate.
// Macro HA_RIPPLE_OVF_EN adds a registered two's-complement overflow output ovf.
module ha_ripple_adder
    import ha_ripple_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef HA_RIPPLE_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Catch illegal widths at elaboration rather than building a broken adder.
    if ((WIDTH < 1) || (WIDTH > MAX_WIDTH)) begin : g_bad_width
        $error("ha_ripple_adder: WIDTH must be in 1..%0d", MAX_WIDTH);
    end

    logic [WIDTH:0]   carry_s;   // carry_s[0] is c_in, carry_s[WIDTH] is the final carry
    logic [WIDTH-1:0] p_s;       // propagate from first half adder
    logic [WIDTH-1:0] q_s;       // generate from first half adder
    logic [WIDTH-1:0] r_s;       // carry produced by second half adder
    logic [WIDTH-1:0] s_s;       // combinational sum bits
    logic [WIDTH-1:0] nq_s;      // inverted generate (NAND of q with itself)
    logic [WIDTH-1:0] nr_s;      // inverted second carry (NAND of r with itself)

    logic [WIDTH-1:0] sum_r;
    logic             c_out_r;
    logic             out_valid_r;

    assign carry_s[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ha_cell u_ha1 (
            .a (a[i]),
            .b (b[i]),
            .s (p_s[i]),
            .c (q_s[i])
        );

        ha_cell u_ha2 (
            .a (p_s[i]),
            .b (carry_s[i]),
            .s (s_s[i]),
            .c (r_s[i])
        );

        // OR of the two half-adder carries built purely from NANDs.
        assign nq_s[i]      = ~(q_s[i] & q_s[i]);
        assign nr_s[i]      = ~(r_s[i] & r_s[i]);
        assign carry_s[i+1] = ~(nq_s[i] & nr_s[i]);
    end

`ifdef HA_RIPPLE_OVF_EN
    logic ovf_s;
    logic ovf_r;

    // Signed overflow: carry into the MSB differs from carry out of it.
    // For WIDTH=1 carry_s[0] is c_in, which is exactly the required case.
    assign ovf_s = carry_s[WIDTH] ^ carry_s[WIDTH-1];
    assign ovf   = ovf_r;
`endif

    // Result register: reset clears, valid operands load, otherwise hold data and drop valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r       <= {WIDTH{1'b0}};
            c_out_r     <= 1'b0;
            out_valid_r <= 1'b0;
`ifdef HA_RIPPLE_OVF_EN
            ovf_r       <= 1'b0;
`endif
        end else if (in_valid) begin
            sum_r       <= s_s;
            c_out_r     <= carry_s[WIDTH];
            out_valid_r <= 1'b1;
`ifdef HA_RIPPLE_OVF_EN
            ovf_r       <= ovf_s;
`endif
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign sum       = sum_r;
    assign c_out     = c_out_r;
    assign out_valid = out_valid_r;

endmodule : ha_ripple_adder

// File: tb/tb_ha_ripple_adder.sv
// Scoreboard bench for ha_ripple_adder at WIDTH 1, 4 and 8.
// Expected results come from plain integer arithmetic on the operands.
// Build with HA_RIPPLE_OVF_EN defined to also check the ovf output.
module tb_ha_ripple_adder;

    typedef struct {
        logic [31:0] sum;
        logic        c_out;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_q = 1'b0;
    logic armed = 1'b0;

    int checks = 0;
    int errors = 0;

    // WIDTH=1 instance signals
    logic       v1 = 1'b0, c1 = 1'b0;
    logic [0:0] a1 = 1'b0, b1 = 1'b0;
    logic       ov1, co1;
    logic [0:0] s1;
    logic       of1;
    // WIDTH=4 instance signals
    logic       v4 = 1'b0, c4 = 1'b0;
    logic [3:0] a4 = 4'h0, b4 = 4'h0;
    logic       ov4, co4;
    logic [3:0] s4;
    logic       of4;
    // WIDTH=8 instance signals
    logic       v8 = 1'b0, c8 = 1'b0;
    logic [7:0] a8 = 8'h00, b8 = 8'h00;
    logic       ov8, co8;
    logic [7:0] s8;
    logic       of8;

    exp_t q1[$];
    exp_t q4[$];
    exp_t q8[$];
    exp_t last1, last4, last8;

    always #5 clk = ~clk;

`ifdef HA_RIPPLE_OVF_EN
    ha_ripple_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .c_in(c1),
                                       .out_valid(ov1), .sum(s1), .c_out(co1), .ovf(of1));
    ha_ripple_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .c_in(c4),
                                       .out_valid(ov4), .sum(s4), .c_out(co4), .ovf(of4));
    ha_ripple_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .c_in(c8),
                                       .out_valid(ov8), .sum(s8), .c_out(co8), .ovf(of8));
`else
    ha_ripple_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .c_in(c1),
                                       .out_valid(ov1), .sum(s1), .c_out(co1));
    ha_ripple_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .c_in(c4),
                                       .out_valid(ov4), .sum(s4), .c_out(co4));
    ha_ripple_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .c_in(c8),
                                       .out_valid(ov8), .sum(s8), .c_out(co8));
    assign of1 = 1'b0;
    assign of4 = 1'b0;
    assign of8 = 1'b0;
`endif

    // Reference: unsigned sum for sum/c_out, signed range test for overflow.
    function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b, logic c);
        exp_t   e;
        longint mask, ma, mb, t, sa, sb, st, lim;
        mask = (64'sd1 <<< w) - 64'sd1;
        ma   = longint'(a) & mask;
        mb   = longint'(b) & mask;
        t    = ma + mb + longint'(c);
        e.sum   = 32'(t & mask);
        e.c_out = ((t >>> w) & 64'sd1) != 64'sd0;
        lim  = 64'sd1 <<< (w - 1);
        sa   = (ma >= lim) ? ma - (64'sd1 <<< w) : ma;
        sb   = (mb >= lim) ? mb - (64'sd1 <<< w) : mb;
        st   = sa + sb + longint'(c);
        e.ovf = (st >= lim) || (st < -lim);
        return e;
    endfunction

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endfunction

    // Compare one instance's outputs at the negedge following a posedge.
    function automatic void monitor(string nm, logic ov, logic [31:0] s, logic co, logic of,
                                    ref exp_t q[$], ref exp_t last);
        exp_t e;
        if (rst_q) begin
            chk({nm, "_rst_valid"}, 32'(ov), 32'd0);
            chk({nm, "_rst_sum"}, s, 32'd0);
            chk({nm, "_rst_cout"}, 32'(co), 32'd0);
`ifdef HA_RIPPLE_OVF_EN
            chk({nm, "_rst_ovf"}, 32'(of), 32'd0);
`endif
            last = '{sum: 32'd0, c_out: 1'b0, ovf: 1'b0};
        end else if (ov) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL %s_unexpected_valid actual=1 required=0 at %0t", nm, $time);
            end else begin
                e = q.pop_front();
                chk({nm, "_sum"}, s, e.sum);
                chk({nm, "_cout"}, 32'(co), 32'(e.c_out));
`ifdef HA_RIPPLE_OVF_EN
                chk({nm, "_ovf"}, 32'(of), 32'(e.ovf));
`endif
                last = e;
            end
        end else begin
            chk({nm, "_hold_sum"}, s, last.sum);
            chk({nm, "_hold_cout"}, 32'(co), 32'(last.c_out));
`ifdef HA_RIPPLE_OVF_EN
            chk({nm, "_hold_ovf"}, 32'(of), 32'(last.ovf));
`endif
        end
    endfunction

    always @(posedge clk) begin
        rst_q <= rst;
        armed <= 1'b1;
    end

    always @(negedge clk) begin
        if (armed) begin
            monitor("w1", ov1, 32'(s1), co1, of1, q1, last1);
            monitor("w4", ov4, 32'(s4), co4, of4, q4, last4);
            monitor("w8", ov8, 32'(s8), co8, of8, q8, last8);
        end
    end

    // Issue the currently driven operands: record expectations, then advance one cycle.
    task automatic tick();
        if (!rst && v1) q1.push_back(model(1, 32'(a1), 32'(b1), c1));
        if (!rst && v4) q4.push_back(model(4, 32'(a4), 32'(b4), c4));
        if (!rst && v8) q8.push_back(model(8, 32'(a8), 32'(b8), c8));
        @(posedge clk);
        #1;
    endtask

    task automatic rand8();
        v8 = ($urandom_range(3, 0) != 0);
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        c8 = 1'($urandom);
    endtask

    logic [2:0] w1_vec [5];

    initial begin
        w1_vec[0] = 3'b111;
        w1_vec[1] = 3'b001;
        w1_vec[2] = 3'b110;
        w1_vec[3] = 3'b011;
        w1_vec[4] = 3'b000;

        // Reset with valid all-ones operands present: they must be discarded.
        @(posedge clk);
        #1;
        rst = 1'b1;
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        v4 = 1'b1; a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
        v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // WIDTH=1 truth vectors back to back; WIDTH=8 random alongside.
        for (int i = 0; i < 5; i++) begin
            v1 = 1'b1;
            {a1, b1, c1} = w1_vec[i];
            rand8();
            if (i == 0) begin
                v4 = 1'b1; a4 = 4'hF; b4 = 4'h1; c4 = 1'b0;
            end else if (i == 1) begin
                v4 = 1'b1; a4 = 4'h7; b4 = 4'h1; c4 = 1'b0;
            end else if (i == 2) begin
                v4 = 1'b1; a4 = 4'h3; b4 = 4'h4; c4 = 1'b0;
            end else begin
                v4 = 1'b0; a4 = 4'h9; b4 = 4'h0; c4 = 1'b0;
            end
            tick();
        end

        // Wrap-around: all-ones + all-ones + 1 on every width.
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        v4 = 1'b1; a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
        v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        tick();

        // Reset mid-stream with valid operands, then resume.
        rst = 1'b1;
        v4 = 1'b1; a4 = 4'h5; b4 = 4'h6; c4 = 1'b1;
        tick();
        rst = 1'b0;
        v4 = 1'b1; a4 = 4'h2; b4 = 4'h2; c4 = 1'b0;
        tick();

        // Random traffic on all three widths.
        for (int i = 0; i < 10000; i++) begin
            v1 = ($urandom_range(3, 0) != 0);
            a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
            v4 = ($urandom_range(3, 0) != 0);
            a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
            rand8();
            tick();
        end

        // Drain and confirm every issued result came out.
        v1 = 1'b0; v4 = 1'b0; v8 = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        @(negedge clk);
        #1;
        chk("w1_drained", 32'(q1.size()), 32'd0);
        chk("w4_drained", 32'(q4.size()), 32'd0);
        chk("w8_drained", 32'(q8.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ha_ripple_adder
